// File: rtl/wb_dma_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_dma_engine
// Word-copy DMA engine. A Wishbone slave port holds the SRC/DST/LEN/CTRL/STATUS
// registers; a Wishbone master port (DMA side of the CPU/DMA bus arbiter)
// performs one read from SRC followed by one write to DST for every word,
// with a single idle cycle between transactions so the arbiter can re-grant.
//
// Optional feature macro: DMA_TIMEOUT_EN
//   defined   : an ack watchdog drops a stalled transaction after TIMEOUT_CYC
//               cycles, sets ERR and returns to IDLE.
//   undefined : the engine waits for ack indefinitely; ERR always reads 0.
// -----------------------------------------------------------------------------
module wb_dma_engine #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_8000,
    parameter int          LEN_W       = 16,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // configuration slave port
    input  logic        cfg_stb_i,
    input  logic        cfg_cyc_i,
    input  logic        cfg_we_i,
    input  logic [3:0]  cfg_sel_i,
    input  logic [31:0] cfg_adr_i,
    input  logic [31:0] cfg_dat_i,
    output logic        cfg_ack_o,
    output logic [31:0] cfg_dat_o,
    // DMA master port
    output logic        dma_stb_o,
    output logic        dma_cyc_o,
    output logic        dma_we_o,
    output logic [3:0]  dma_sel_o,
    output logic [31:0] dma_adr_o,
    output logic [31:0] dma_dat_o,
    input  logic        dma_ack_i,
    input  logic [31:0] dma_dat_i,
    // interrupt
    output logic        irq_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        GAP_W = 3'd2,
        WR    = 3'd3,
        GAP_R = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_SRC    = 3'd2;
    localparam logic [2:0] OFF_DST    = 3'd3;
    localparam logic [2:0] OFF_LEN    = 3'd4;

    // Replace only the byte lanes that are selected.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    state_t            state, next_state;

    // programmed registers
    logic [31:0]       src_reg;
    logic [31:0]       dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              irq_en;
    logic              done_q;
    logic              err_q;

    // working copies used during a transfer
    logic [31:0]       src_cur;
    logic [31:0]       dst_cur;
    logic [LEN_W-1:0]  rem;
    logic [31:0]       copy_buf;
    logic              abort_pend;

    // FSM side effects
    logic              fin_set;
    logic              err_set;
    logic              tmo_hit;

    // ------------------------------------------------------- config decode
    logic        cfg_hit;
    logic        cfg_req;
    logic        cfg_wr;
    logic [2:0]  cfg_off;
    logic        ctrl_wr;
    logic        stat_wr;
    logic        start_bit;
    logic        abort_bit;
    logic        start_go;
    logic        abort_wr;
    logic        abort_now;
    logic        done_clr;
    logic        err_clr;
    logic        busy;
    logic [15:0] rem_word;
    logic [31:0] rd_data;
    logic        unused_adr_bits;

    assign unused_adr_bits = ^cfg_adr_i[1:0];

    assign cfg_hit  = (cfg_adr_i[31:5] == BASE_ADDR[31:5]);
    // The !cfg_ack_o term makes a held strobe complete every other cycle.
    assign cfg_req  = cfg_stb_i & cfg_cyc_i & cfg_hit & ~cfg_ack_o;
    assign cfg_wr   = cfg_req & cfg_we_i;
    assign cfg_off  = cfg_adr_i[4:2];

    // CTRL and STATUS only look at byte lane 0.
    assign ctrl_wr  = cfg_wr & (cfg_off == OFF_CTRL)   & cfg_sel_i[0];
    assign stat_wr  = cfg_wr & (cfg_off == OFF_STATUS) & cfg_sel_i[0];

    assign busy      = (state != IDLE);
    assign start_bit = ctrl_wr & cfg_dat_i[0];
    assign abort_bit = ctrl_wr & cfg_dat_i[2];
    // ABORT written together with START cancels the START.
    assign start_go  = start_bit & ~abort_bit & ~busy;
    assign abort_wr  = abort_bit & busy;
    assign abort_now = abort_wr | abort_pend;
    assign done_clr  = stat_wr & cfg_dat_i[1];
    assign err_clr   = stat_wr & cfg_dat_i[2];

    assign rem_word  = 16'(rem);

    // Register read multiplexer; unmapped offsets read as zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        rd_data = '0;
        case (cfg_off)
            OFF_CTRL:   rd_data = {30'd0, irq_en, 1'b0};
            OFF_STATUS: rd_data = {rem_word, 13'd0, err_q, done_q, busy};
            OFF_SRC:    rd_data = src_reg;
            OFF_DST:    rd_data = dst_reg;
            OFF_LEN:    rd_data = 32'(len_reg);
            default:    rd_data = '0;
        endcase
    end

    // Config slave: registered ack/read data, register writes, DONE/ERR flags.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (wb_rst_i) begin
            cfg_ack_o <= 1'b0;
            cfg_dat_o <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            irq_en    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cfg_ack_o <= cfg_req;
            cfg_dat_o <= (cfg_req && !cfg_we_i) ? rd_data : '0;

            if (ctrl_wr) irq_en <= cfg_dat_i[1];

            // Programming registers are frozen while a transfer runs.
            if (cfg_wr && !busy) begin
                case (cfg_off)
                    OFF_SRC: src_reg <= merge_lanes(src_reg, cfg_dat_i, cfg_sel_i);
                    OFF_DST: dst_reg <= merge_lanes(dst_reg, cfg_dat_i, cfg_sel_i);
                    OFF_LEN: len_reg <= LEN_W'(merge_lanes(32'(len_reg), cfg_dat_i, cfg_sel_i));
                    default: ;
                endcase
            end

            // A hardware set in the same cycle as a W1C clear takes priority.
            done_q <= fin_set | (done_q & ~done_clr);
            err_q  <= err_set | (err_q  & ~err_clr);
        end
    end

    // ------------------------------------------------------ ack watchdog
`ifdef DMA_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TMO_W-1:0] tmo_cnt;

    // Count stalled cycles of the current request; restart on ack or idle.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt <= '0;
        end else if (!dma_stb_o || dma_ack_i) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign tmo_hit = dma_stb_o & ~dma_ack_i & (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------- FSM
    // State register; reset is asynchronous so the master strobe drops at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic and master-port drive.
    always_comb begin
        next_state = state;
        dma_stb_o  = 1'b0;
        dma_we_o   = 1'b0;
        dma_adr_o  = '0;
        fin_set    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start_go) next_state = (len_reg == '0) ? FIN : RD;
            end
            RD: begin
                dma_stb_o = 1'b1;
                dma_adr_o = src_cur;
                if (dma_ack_i) begin
                    next_state = abort_now ? IDLE : GAP_W;
                end else if (tmo_hit) begin
                    next_state = IDLE;
                    err_set    = 1'b1;
                end
            end
            GAP_W: begin
                next_state = abort_now ? IDLE : WR;
            end
            WR: begin
                dma_stb_o = 1'b1;
                dma_we_o  = 1'b1;
                dma_adr_o = dst_cur;
                if (dma_ack_i) begin
                    if (abort_now)               next_state = IDLE;
                    else if (rem == LEN_W'(1))   next_state = FIN;
                    else                         next_state = GAP_R;
                end else if (tmo_hit) begin
                    next_state = IDLE;
                    err_set    = 1'b1;
                end
            end
            GAP_R: begin
                next_state = abort_now ? IDLE : RD;
            end
            FIN: begin
                next_state = IDLE;
                fin_set    = ~abort_now;
            end
            default: next_state = IDLE;
        endcase
    end

    assign dma_cyc_o = dma_stb_o;
    assign dma_sel_o = dma_stb_o ? 4'hF : 4'h0;
    assign dma_dat_o = copy_buf;
    assign irq_o     = irq_en & (done_q | err_q);

    // Transfer datapath: working pointers, remaining count and copy buffer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            src_cur  <= '0;
            dst_cur  <= '0;
            rem      <= '0;
            copy_buf <= '0;
        end else if (start_go) begin
            src_cur <= src_reg;
            dst_cur <= dst_reg;
            rem     <= len_reg;
        end else if (dma_ack_i && state == RD) begin
            copy_buf <= dma_dat_i;
            src_cur  <= src_cur + 32'd4;
        end else if (dma_ack_i && state == WR) begin
            dst_cur <= dst_cur + 32'd4;
            rem     <= rem - LEN_W'(1);
        end
    end

    // Remember an ABORT until the in-flight transaction has been acked.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                 abort_pend <= 1'b0;
        else if (next_state == IDLE)  abort_pend <= 1'b0;
        else if (abort_wr)            abort_pend <= 1'b1;
    end

endmodule

// File: tb/tb_wb_dma_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wb_dma_engine
// Directed bench for wb_dma_engine. A behavioural slave on the DMA port
// returns data derived from the address; expected reads and writes are queued
// when a transfer is programmed and popped as the engine acks each one.
// Define DMA_TIMEOUT_EN to also exercise the ack watchdog (TIMEOUT_CYC=16).
// -----------------------------------------------------------------------------
module tb_wb_dma_engine;

    localparam logic [31:0] BASE = 32'h3000_8000;
`ifdef DMA_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    localparam logic [4:0] R_CTRL   = 5'h00;
    localparam logic [4:0] R_STATUS = 5'h04;
    localparam logic [4:0] R_SRC    = 5'h08;
    localparam logic [4:0] R_DST    = 5'h0C;
    localparam logic [4:0] R_LEN    = 5'h10;

    logic        wb_clk_i, wb_rst_i;
    logic        cfg_stb_i, cfg_cyc_i, cfg_we_i;
    logic [3:0]  cfg_sel_i;
    logic [31:0] cfg_adr_i, cfg_dat_i;
    logic        cfg_ack_o;
    logic [31:0] cfg_dat_o;
    logic        dma_stb_o, dma_cyc_o, dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_adr_o, dma_dat_o;
    logic        dma_ack_i;
    logic [31:0] dma_dat_i;
    logic        irq_o;

    wb_dma_engine #(
        .BASE_ADDR   (BASE),
        .LEN_W       (16),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cfg_stb_i (cfg_stb_i),
        .cfg_cyc_i (cfg_cyc_i),
        .cfg_we_i  (cfg_we_i),
        .cfg_sel_i (cfg_sel_i),
        .cfg_adr_i (cfg_adr_i),
        .cfg_dat_i (cfg_dat_i),
        .cfg_ack_o (cfg_ack_o),
        .cfg_dat_o (cfg_dat_o),
        .dma_stb_o (dma_stb_o),
        .dma_cyc_o (dma_cyc_o),
        .dma_we_o  (dma_we_o),
        .dma_sel_o (dma_sel_o),
        .dma_adr_o (dma_adr_o),
        .dma_dat_o (dma_dat_o),
        .dma_ack_i (dma_ack_i),
        .dma_dat_i (dma_dat_i),
        .irq_o     (irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int last_cfg_cyc = 0;

    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_t;

    logic [31:0] exp_rd[$];
    wr_t         exp_wr[$];
    int          rises[$];
    int          falls[$];

    bit no_ack      = 1'b0;
    int slow_wr_idx = -1;
    int slow_dly    = 0;
    int wr_seen     = 0;
    int stb_cycles  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Slave memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic plan_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] s, d;
        wr_t w;
        s = src;
        d = dst;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(s);
            w.adr = d;
            w.dat = mdata(s);
            exp_wr.push_back(w);
            s = s + 32'd4;
            d = d + 32'd4;
        end
    endtask

    // Behavioural DMA-side slave with per-test ack delay and scoreboard checks.
    initial begin
        int  wait_cnt;
        int  dly;
        bit  prev_stb;
        wr_t w;
        logic [31:0] a;
        wait_cnt  = 0;
        prev_stb  = 1'b0;
        dma_ack_i = 1'b0;
        dma_dat_i = '0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (dma_stb_o && !prev_stb) rises.push_back(cyc_n);
            if (!dma_stb_o && prev_stb) falls.push_back(cyc_n);
            prev_stb = dma_stb_o;
            if (dma_stb_o) stb_cycles++;
            dma_ack_i = 1'b0;
            if (dma_stb_o && !wb_rst_i && !no_ack) begin
                dly = (dma_we_o && wr_seen == slow_wr_idx) ? slow_dly : 0;
                if (wait_cnt >= dly) begin
                    wait_cnt  = 0;
                    dma_ack_i = 1'b1;
                    check("dma_cyc_eq_stb", 32'(dma_cyc_o), 32'd1);
                    check("dma_sel", 32'(dma_sel_o), 32'hF);
                    if (!dma_we_o) begin
                        dma_dat_i = mdata(dma_adr_o);
                        check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                        if (exp_rd.size() != 0) begin
                            a = exp_rd.pop_front();
                            check("rd_adr", dma_adr_o, a);
                        end
                    end else begin
                        wr_seen++;
                        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                        if (exp_wr.size() != 0) begin
                            w = exp_wr.pop_front();
                            check("wr_adr", dma_adr_o, w.adr);
                            check("wr_dat", dma_dat_o, w.dat);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cfg_write(input logic [4:0] off, input logic [31:0] dat, input logic [3:0] sel);
        @(negedge wb_clk_i);
        cfg_adr_i = BASE + 32'(off);
        cfg_dat_i = dat;
        cfg_sel_i = sel;
        cfg_we_i  = 1'b1;
        cfg_stb_i = 1'b1;
        cfg_cyc_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        last_cfg_cyc = cyc_n;
        @(negedge wb_clk_i);
        check("cfg_wr_ack", 32'(cfg_ack_o), 32'd1);
        cfg_stb_i = 1'b0;
        cfg_cyc_i = 1'b0;
        cfg_we_i  = 1'b0;
    endtask

    task automatic cfg_read(input logic [4:0] off, output logic [31:0] dat);
        @(negedge wb_clk_i);
        cfg_adr_i = BASE + 32'(off);
        cfg_sel_i = 4'hF;
        cfg_we_i  = 1'b0;
        cfg_stb_i = 1'b1;
        cfg_cyc_i = 1'b1;
        @(negedge wb_clk_i);
        check("cfg_rd_ack", 32'(cfg_ack_o), 32'd1);
        dat       = cfg_dat_o;
        cfg_stb_i = 1'b0;
        cfg_cyc_i = 1'b0;
    endtask

    // Poll STATUS until BUSY clears (bounded); returns the final STATUS.
    task automatic wait_idle(input string tag, output logic [31:0] st);
        for (int i = 0; i < 150; i++) begin
            cfg_read(R_STATUS, st);
            if (!st[0]) break;
        end
        check(tag, 32'(st[0]), 32'd0);
    endtask

    task automatic check_regs_zero(input string tag);
        logic [31:0] v;
        cfg_read(R_CTRL, v);   check({tag, "_ctrl"}, v, 32'd0);
        cfg_read(R_STATUS, v); check({tag, "_status"}, v, 32'd0);
        cfg_read(R_SRC, v);    check({tag, "_src"}, v, 32'd0);
        cfg_read(R_DST, v);    check({tag, "_dst"}, v, 32'd0);
        cfg_read(R_LEN, v);    check({tag, "_len"}, v, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [31:0] v;
        int start_cyc;
        int base_stb;
        bit reached;

        wb_rst_i  = 1'b1;
        cfg_stb_i = 1'b0;
        cfg_cyc_i = 1'b0;
        cfg_we_i  = 1'b0;
        cfg_sel_i = 4'h0;
        cfg_adr_i = '0;
        cfg_dat_i = '0;

        // ---- reset state
        repeat (3) @(negedge wb_clk_i);
        check("rst_dma_stb", 32'(dma_stb_o), 32'd0);
        check("rst_dma_cyc", 32'(dma_cyc_o), 32'd0);
        check("rst_dma_adr", dma_adr_o, 32'd0);
        check("rst_dma_dat", dma_dat_o, 32'd0);
        check("rst_cfg_ack", 32'(cfg_ack_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        wb_rst_i = 1'b0;
        check_regs_zero("rst_reg");

        // ---- basic 4-word copy with 1-cycle-ack memory
        plan_copy(32'h3800_0000, 32'h3800_0100, 4);
        cfg_write(R_SRC, 32'h3800_0000, 4'hF);
        cfg_write(R_DST, 32'h3800_0100, 4'hF);
        cfg_write(R_LEN, 32'd4, 4'hF);
        rises.delete();
        cfg_write(R_CTRL, 32'h1, 4'hF);
        start_cyc = last_cfg_cyc;
        wait_idle("t1_idle", v);
        check("t1_status", v, 32'h0000_0002);
        check("t1_rises", 32'(rises.size()), 32'd8);
        check("t1_first_stb", 32'(rises.size() > 0 ? rises[0] : -1), 32'(start_cyc));
        for (int i = 1; i < rises.size(); i++) check("t1_gap", 32'(rises[i] - rises[i-1]), 32'd2);
        check("t1_rd_left", 32'(exp_rd.size()), 32'd0);
        check("t1_wr_left", 32'(exp_wr.size()), 32'd0);
        cfg_write(R_STATUS, 32'h6, 4'hF);

        // ---- LEN=0 with IRQ_EN: no bus traffic, DONE and irq
        cfg_write(R_LEN, 32'd0, 4'hF);
        base_stb = stb_cycles;
        cfg_write(R_CTRL, 32'h3, 4'hF);
        for (int i = 0; i < 2 && !irq_o; i++) @(negedge wb_clk_i);
        check("t2_irq_set", 32'(irq_o), 32'd1);
        cfg_read(R_STATUS, v);
        check("t2_status", v, 32'h0000_0002);
        check("t2_no_bus", 32'(stb_cycles - base_stb), 32'd0);
        cfg_write(R_STATUS, 32'h2, 4'hF);
        check("t2_irq_clr", 32'(irq_o), 32'd0);
        cfg_write(R_CTRL, 32'h0, 4'hF);

        // ---- byte lanes: SRC honours sel, CTRL needs lane 0
        cfg_write(R_SRC, 32'hFFFF_FFFF, 4'hF);
        cfg_write(R_SRC, 32'h1234_5678, 4'b0101);
        cfg_read(R_SRC, v);
        check("lanes_src", v, 32'hFF34_FF78);
        cfg_write(R_CTRL, 32'h2, 4'b1110);
        cfg_read(R_CTRL, v);
        check("lanes_ctrl", v, 32'd0);

        // ---- address wrap 0xFFFF_FFFC + 4 -> 0
        plan_copy(32'hFFFF_FFF8, 32'h3800_0300, 3);
        cfg_write(R_SRC, 32'hFFFF_FFF8, 4'hF);
        cfg_write(R_DST, 32'h3800_0300, 4'hF);
        cfg_write(R_LEN, 32'd3, 4'hF);
        cfg_write(R_CTRL, 32'h1, 4'hF);
        wait_idle("wrap_idle", v);
        check("wrap_status", v, 32'h0000_0002);
        check("wrap_rd_left", 32'(exp_rd.size()), 32'd0);
        check("wrap_wr_left", 32'(exp_wr.size()), 32'd0);
        cfg_write(R_STATUS, 32'h6, 4'hF);

        // ---- START and ABORT together: nothing starts
        base_stb = stb_cycles;
        cfg_write(R_CTRL, 32'h5, 4'hF);
        repeat (4) @(negedge wb_clk_i);
        check("sa_no_bus", 32'(stb_cycles - base_stb), 32'd0);
        cfg_read(R_STATUS, v);
        check("sa_status", v, 32'h0000_0000);

        // ---- SRC write while busy is ignored; copy unaffected
        plan_copy(32'h3800_0400, 32'h3800_0800, 8);
        cfg_write(R_SRC, 32'h3800_0400, 4'hF);
        cfg_write(R_DST, 32'h3800_0800, 4'hF);
        cfg_write(R_LEN, 32'd8, 4'hF);
        rises.delete();
        cfg_write(R_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 200 && rises.size() < 3; i++) @(negedge wb_clk_i);
        check("t3_progress", 32'(rises.size() >= 3), 32'd1);
        cfg_write(R_SRC, 32'hDEAD_0000, 4'hF);
        cfg_read(R_SRC, v);
        check("t3_src_kept", v, 32'h3800_0400);
        wait_idle("t3_idle", v);
        check("t3_status", v, 32'h0000_0002);
        check("t3_rd_left", 32'(exp_rd.size()), 32'd0);
        check("t3_wr_left", 32'(exp_wr.size()), 32'd0);
        cfg_write(R_STATUS, 32'h6, 4'hF);

        // ---- ABORT during the 3rd write, which is acked 5 cycles late
        plan_copy(32'h3800_1000, 32'h3800_2000, 3);
        cfg_write(R_SRC, 32'h3800_1000, 4'hF);
        cfg_write(R_DST, 32'h3800_2000, 4'hF);
        cfg_write(R_LEN, 32'd8, 4'hF);
        wr_seen     = 0;
        slow_wr_idx = 2;
        slow_dly    = 5;
        rises.delete();
        cfg_write(R_CTRL, 32'h1, 4'hF);
        reached = 1'b0;
        for (int i = 0; i < 300 && !reached; i++) begin
            @(negedge wb_clk_i);
            reached = (wr_seen == 2) && dma_stb_o && dma_we_o && !dma_ack_i;
        end
        check("t4_in_wr3", 32'(reached), 32'd1);
        cfg_write(R_CTRL, 32'h4, 4'hF);
        wait_idle("t4_idle", v);
        check("t4_status", v, 32'h0005_0000);
        repeat (10) @(negedge wb_clk_i);
        check("t4_rises", 32'(rises.size()), 32'd6);
        check("t4_rd_left", 32'(exp_rd.size()), 32'd0);
        check("t4_wr_left", 32'(exp_wr.size()), 32'd0);
        check("t4_irq", 32'(irq_o), 32'd0);
        slow_wr_idx = -1;

        // ---- async reset while a read is pending
        no_ack = 1'b1;
        cfg_write(R_LEN, 32'd2, 4'hF);
        cfg_write(R_CTRL, 32'h1, 4'hF);
        for (int i = 0; i < 10 && !dma_stb_o; i++) @(negedge wb_clk_i);
        check("t5_rd_pending", 32'({dma_stb_o, dma_we_o}), 32'b10);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("t5_stb_drop", 32'(dma_stb_o), 32'd0);
        check("t5_cyc_drop", 32'(dma_cyc_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        no_ack   = 1'b0;
        check_regs_zero("t5_reg");

`ifdef DMA_TIMEOUT_EN
        // ---- ack watchdog: slave never acks
        no_ack = 1'b1;
        cfg_write(R_SRC, 32'h3800_0000, 4'hF);
        cfg_write(R_DST, 32'h3800_0100, 4'hF);
        cfg_write(R_LEN, 32'd1, 4'hF);
        rises.delete();
        falls.delete();
        cfg_write(R_CTRL, 32'h3, 4'hF);
        for (int i = 0; i < 100 && falls.size() < 1; i++) @(negedge wb_clk_i);
        check("t6_fell", 32'(falls.size() >= 1 && rises.size() >= 1), 32'd1);
        if (falls.size() >= 1 && rises.size() >= 1)
            check("t6_stb_len", 32'(falls[0] - rises[0]), 32'd16);
        no_ack = 1'b0;
        cfg_read(R_STATUS, v);
        check("t6_status", v, 32'h0001_0004);
        check("t6_irq", 32'(irq_o), 32'd1);
        cfg_write(R_STATUS, 32'h4, 4'hF);
        check("t6_irq_clr", 32'(irq_o), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
